// File: rtl/div_exp_norm.sv
// Exponent-restoring / normalizing stage of the FP divider: rebias the signed
// exponent difference, left-normalize the quotient one bit per cycle, then pack.
module div_exp_norm #(
    parameter int BIAS = 127
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  diff_mag,
    input  logic        diff_pos,
    input  logic [24:0] quo,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_exp,
    output logic [22:0] out_mant,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_zero
);

    localparam int unsigned EW = 11;
    localparam int unsigned QW = 25;
    localparam int unsigned XW = 8;
    localparam int unsigned MW = 23;

    localparam logic signed [EW-1:0] E_MAX = EW'(255);
    localparam logic signed [EW-1:0] E_MIN = EW'(0);
    localparam logic signed [EW-1:0] E_ONE = EW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_PACK = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic signed [EW-1:0]  r_e;
    logic        [QW-1:0]  r_q;
    logic                  r_zero;

    logic                  w_accept;
    logic signed [EW-1:0]  w_diff;
    logic signed [EW-1:0]  w_e_init;
    logic        [XW-1:0]  w_pack_exp;
    logic        [MW-1:0]  w_pack_mant;
    logic                  w_pack_ovf;
    logic                  w_pack_unf;
    logic                  w_pack_zero;

    // A negative zero difference yields the same value as a positive zero.
    assign w_diff   = diff_pos ? EW'({2'b00, diff_mag}) : -EW'({2'b00, diff_mag});
    assign w_e_init = w_diff + EW'(BIAS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_NORM;
            S_NORM: if ((r_q == '0) || r_q[QW-1]) w_next = S_PACK;
            S_PACK: w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Handshake and the packed result presented while in PACK.
    always_comb begin
        in_ready    = (r_state == S_IDLE);
        w_accept    = in_valid && in_ready;
        w_pack_exp  = '0;
        w_pack_mant = '0;
        w_pack_ovf  = 1'b0;
        w_pack_unf  = 1'b0;
        w_pack_zero = 1'b0;
        if (r_zero) begin
            w_pack_zero = 1'b1;
        end else if (r_e >= E_MAX) begin
            w_pack_exp = '1;
            w_pack_ovf = 1'b1;
        end else if (r_e <= E_MIN) begin
            w_pack_unf = 1'b1;
        end else begin
            w_pack_exp  = r_e[XW-1:0];
            w_pack_mant = r_q[QW-2:1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e    <= '0;
            r_q    <= '0;
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_e    <= w_e_init;
                        r_q    <= quo;
                        r_zero <= 1'b0;
                    end
                end
                S_NORM: begin
                    if (r_q == '0) begin
                        r_zero <= 1'b1;
                    end else if (!r_q[QW-1]) begin
                        r_q <= r_q << 1;
                        r_e <= r_e - E_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers load on leaving PACK and hold until the next PACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_exp   <= '0;
            out_mant  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (r_state == S_PACK) begin
            out_valid <= 1'b1;
            out_exp   <= w_pack_exp;
            out_mant  <= w_pack_mant;
            out_ovf   <= w_pack_ovf;
            out_unf   <= w_pack_unf;
            out_zero  <= w_pack_zero;
        end else if ((r_state == S_DONE) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_exp_norm.sv
// Self-checking bench for div_exp_norm: directed and random operations against
// an arithmetic reference model, including hold, ignored input and mid-op reset.
module tb_div_exp_norm;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  diff_mag;
    logic        diff_pos;
    logic [24:0] quo;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_exp;
    logic [22:0] out_mant;
    logic        out_ovf;
    logic        out_unf;
    logic        out_zero;

    int n_vec;
    int n_checks;
    int n_fail;

    div_exp_norm #(.BIAS(127)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff_mag  (diff_mag),
        .diff_pos  (diff_pos),
        .quo       (quo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: real-valued normalization of quo, exponent adjusted by the shift.
    task automatic run_op(input logic pos, input logic [8:0] mag, input logic [24:0] q,
                          input int hold);
        int          e;
        int          k;
        int          msb;
        int          lat;
        logic [24:0] nq;
        logic [7:0]  x_exp;
        logic [22:0] x_mant;
        logic        x_ovf;
        logic        x_unf;
        logic        x_zero;

        e   = (pos ? int'(mag) : -int'(mag)) + 127;
        msb = -1;
        for (int b = 0; b < 25; b++) if (q[b]) msb = b;
        k      = (msb < 0) ? 0 : 24 - msb;
        e      = e - k;
        nq     = q << k;
        x_exp  = 8'd0;
        x_mant = 23'd0;
        x_ovf  = 1'b0;
        x_unf  = 1'b0;
        x_zero = 1'b0;
        if (q == 25'd0)   x_zero = 1'b1;
        else if (e >= 255) begin x_exp = 8'hFF; x_ovf = 1'b1; end
        else if (e <= 0)  x_unf = 1'b1;
        else begin x_exp = 8'(e); x_mant = nq[23:1]; end

        @(negedge clk);
        chk("ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        diff_pos = pos;
        diff_mag = mag;
        quo      = q;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("ready_busy", 32'(in_ready), 32'd0);

        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        chk("latency", 32'(lat), 32'(2 + k));
        chk("exp", 32'(out_exp), 32'(x_exp));
        chk("mant", 32'(out_mant), 32'(x_mant));
        chk("ovf", 32'(out_ovf), 32'(x_ovf));
        chk("unf", 32'(out_unf), 32'(x_unf));
        chk("zero", 32'(out_zero), 32'(x_zero));

        // Stall with a stray request that must be ignored.
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = 1'b1;
            diff_pos = 1'b1;
            diff_mag = 9'd7;
            quo      = 25'h1FFFFFF;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_exp", 32'(out_exp), 32'(x_exp));
            chk("hold_mant", 32'(out_mant), 32'(x_mant));
        end

        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_ready", 32'(in_ready), 32'd1);
        chk("drain_exp", 32'(out_exp), 32'(x_exp));
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++;
    endtask

    initial begin
        n_vec     = 0;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        diff_pos  = 1'b0;
        diff_mag  = 9'd0;
        quo       = 25'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_exp", 32'(out_exp), 32'd0);
        chk("rst_flags", 32'({out_ovf, out_unf, out_zero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b1, 9'd0,   25'h1000000, 0);
        run_op(1'b0, 9'd3,   25'h0C00000, 1);
        run_op(1'b1, 9'd128, 25'h1800000, 0);
        run_op(1'b1, 9'd128, 25'h1000000, 0);
        run_op(1'b0, 9'd126, 25'h0800000, 0);
        run_op(1'b0, 9'd126, 25'h1000000, 0);
        run_op(1'b1, 9'd0,   25'h0000001, 0);
        run_op(1'b0, 9'd0,   25'h1000000, 0);
        run_op(1'b1, 9'd5,   25'h0000000, 5);
        run_op(1'b0, 9'd511, 25'h1FFFFFF, 0);
        run_op(1'b1, 9'd511, 25'h0000003, 0);

        // Reset in the middle of a long normalization discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        diff_pos = 1'b1;
        diff_mag = 9'd1;
        quo      = 25'h0000001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_exp", 32'(out_exp), 32'd0);
        chk("mid_rst_mant", 32'(out_mant), 32'd0);
        chk("mid_rst_flags", 32'({out_ovf, out_unf, out_zero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [24:0] rq;
            rq = 25'($urandom) >> $urandom_range(0, 25);
            run_op(1'($urandom), 9'($urandom_range(0, 300)), rq, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/div_exp_norm.md
# div_exp_norm

Sequential exponent-restoring and normalizing stage of the floating-point divider. It sits after `sub_exp` and the significand divider. It consumes the sign/magnitude exponent difference that `sub_exp` produces, plus the raw significand quotient. It re-applies the bias, normalizes the quotient one bit per cycle, and emits a packed biased exponent and fraction with overflow/underflow/zero flags over a valid/ready handshake.

## Interface
Parameters:
- BIAS, 127, exponent bias added back to the signed difference.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept operands.
- diff_mag  in  9  magnitude |ex − ey|, as produced by `sub_exp`.
- diff_pos  in  1  sign of the difference: 1 when ex ≥ ey (carry of the subtract), 0 otherwise.
- quo  in  25  significand quotient; bit 24 has weight 1.0, bit 0 has weight 2^-24.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_exp  out  8  biased result exponent.
- out_mant  out  23  result fraction, hidden bit dropped.
- out_ovf  out  1  exponent overflow.
- out_unf  out  1  exponent underflow (flushed to zero).
- out_zero  out  1  quotient was zero.

## Operation
- States: IDLE, NORM, PACK, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch e = (diff_pos ? +diff_mag : −diff_mag) + BIAS into an 11-bit signed register, latch q = quo, then go to NORM.
  - diff_pos=0 with diff_mag=0 is treated as +0.
- NORM:
  - If q==0: set zero flag, go to PACK.
  - Else if q[24]==1: go to PACK.
  - Else: q <= q<<1 and e <= e−1 in the same cycle, then stay in NORM.
  - At most 24 shift cycles.
- PACK (single cycle, results registered on exit):
  - Zero: out_exp=0, out_mant=0, out_zero=1.
  - Else if e ≥ 255: out_exp=255, out_mant=0, out_ovf=1.
  - Else if e ≤ 0: out_exp=0, out_mant=0, out_unf=1. No denormal output.
  - Else: out_exp=e[7:0], out_mant=q[23:1]. Truncation only; q[0] is discarded.
  - Go to DONE with out_valid=1.
- DONE:
  - Hold all outputs stable while out_ready=0.
  - On out_ready=1: out_valid <= 0 and go to IDLE. Flags and data remain until the next PACK.
- Flags are mutually exclusive; at most one of out_ovf/out_unf/out_zero is 1.
- Signed arithmetic: all exponent math is 11-bit two's complement. The range −511+BIAS−24 … 511+BIAS fits without wrap.

## Timing
- Reset: state=IDLE, in_ready=1 (combinational from state), out_valid=0. out_exp, out_mant and all flags are 0.
- Reset asserted in any state aborts the operation on that edge with no output; the latched operand is discarded.
- Latency: accept edge T → out_valid high after edge T+2+k, where k = leading zeros of quo above bit 24 (0…24).
  - quo==0 gives latency 2.
- One operation in flight. in_ready=0 from the cycle after accept until the cycle after the out_valid&out_ready handshake; there is no same-cycle bypass.
- in_valid is ignored while in_ready=0.
- out_ready may be held high continuously; minimum throughput is one result per 4+k cycles.

## Test plan
- Normal, no shift: diff_pos=1, diff_mag=0, quo=0x1000000 → out_exp=127, out_mant=0, no flags, out_valid 2 cycles after accept.
- One shift: diff_pos=0, diff_mag=3, quo=0x0C00000 → out_exp=123, out_mant=0x400000, out_valid 3 cycles after accept.
- Overflow: diff_pos=1, diff_mag=128, quo=0x1800000 → out_exp=255, out_mant=0, out_ovf=1.
- Underflow: diff_pos=0, diff_mag=126, quo=0x0800000 → e=0 → out_exp=0, out_mant=0, out_unf=1. Also quo=0x0000001, diff_mag=0 → 24 shifts, out_exp=103, out_mant=0.
- Zero: quo=0 → out_zero=1, out_exp=0, out_mant=0, latency 2.
- Handshake/reset:
  - out_ready low for 5 cycles → outputs and out_valid held, in_ready=0, and an in_valid pulse is ignored.
  - rst pulse during NORM → next cycle state IDLE, in_ready=1, out_valid=0, outputs 0.
